// File: rtl/mm_iddmm_loader.sv
// Host-side initiator for mm_iddmm_sp: loads N operand words, runs one task,
// buffers the N result words and replays them downstream. Optional RUN
// watchdog enabled by defining IDDMM_LD_TIMEOUT_EN.
module mm_iddmm_loader #(
  parameter  int K       = 128,
  parameter  int N       = 32,
  parameter  int TIMEOUT = 65536,
  localparam int AW      = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [K-1:0]  in_x,
  input  logic [K-1:0]  in_y,
  input  logic [K-1:0]  in_m,
  input  logic [K-1:0]  in_m1,
  output logic          wr_ena,
  output logic [AW-1:0] wr_addr,
  output logic [K-1:0]  wr_x,
  output logic [K-1:0]  wr_y,
  output logic [K-1:0]  wr_m,
  output logic [K-1:0]  wr_m1,
  output logic          task_req,
  input  logic          task_end,
  input  logic          res_val,
  input  logic [K-1:0]  res,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [K-1:0]  out_data,
  output logic          out_last,
  output logic          busy,
  output logic          err
);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DRAIN} state_t;

  localparam logic [AW:0] LAST_IDX = (AW+1)'(N - 1);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(N);

  state_t        state;
  logic [AW:0]   ld_ptr;
  logic [AW:0]   cap_ptr;
  logic [AW:0]   rd_ptr;
  logic [K-1:0]  res_buf [N];

  // N is a power of two, so the top pointer bit alone flags "N captured".
  logic          cap_full;
  logic          cap_we;
  logic [AW:0]   cap_next;
  logic [AW-1:0] rd_nxt;

  assign cap_full = cap_ptr[AW];
  assign cap_we   = (state == RUN) && res_val && !cap_full;
  assign cap_next = cap_ptr + (AW+1)'(cap_we);
  assign rd_nxt   = rd_ptr[AW-1:0] + AW'(1);
  assign busy     = (state != IDLE);

`ifdef IDDMM_LD_TIMEOUT_EN
  localparam int            WW     = $clog2(TIMEOUT + 1);
  localparam logic [WW-1:0] WD_MAX = WW'(TIMEOUT - 1);
  logic [WW-1:0] wd_cnt;
`endif

  // NOTE: storage arrays are not reset; every entry is written before it is read.
  always_ff @(posedge clk) begin
    if (cap_we) res_buf[cap_ptr[AW-1:0]] <= res;
  end

  // NOTE: all state updates use non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ld_ptr    <= '0;
      cap_ptr   <= '0;
      rd_ptr    <= '0;
      in_ready  <= 1'b0;
      wr_ena    <= 1'b0;
      wr_addr   <= '0;
      wr_x      <= '0;
      wr_y      <= '0;
      wr_m      <= '0;
      wr_m1     <= '0;
      task_req  <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      err       <= 1'b0;
`ifdef IDDMM_LD_TIMEOUT_EN
      wd_cnt    <= '0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            state    <= LOAD;
            in_ready <= 1'b1;
            err      <= 1'b0;
            ld_ptr   <= '0;
            cap_ptr  <= '0;
            rd_ptr   <= '0;
`ifdef IDDMM_LD_TIMEOUT_EN
            wd_cnt   <= '0;
`endif
          end
        end

        LOAD: begin
          wr_ena <= 1'b0;
          if (in_valid && in_ready) begin
            wr_ena  <= 1'b1;
            wr_addr <= ld_ptr[AW-1:0];
            wr_x    <= in_x;
            wr_y    <= in_y;
            wr_m    <= in_m;
            wr_m1   <= in_m1;
            ld_ptr  <= ld_ptr + 1'b1;
            if (ld_ptr == LAST_IDX) begin
              in_ready <= 1'b0;
              state    <= RUN;
            end
          end
        end

        RUN: begin
          wr_ena  <= 1'b0;
          cap_ptr <= cap_next;
          if (res_val && cap_full) err <= 1'b1;
          // First RUN cycle still shows the last write pulse; request follows it.
          if (wr_ena) begin
            task_req <= 1'b1;
          end else if (task_req && task_end) begin
            task_req <= 1'b0;
            if (cap_next == FULL_CNT) begin
              state     <= DRAIN;
              out_valid <= 1'b1;
              out_data  <= res_buf[0];
              out_last  <= 1'b0;
              rd_ptr    <= '0;
            end else begin
              err   <= 1'b1;
              state <= IDLE;
            end
          end
`ifdef IDDMM_LD_TIMEOUT_EN
          else if (wd_cnt == WD_MAX) begin
            task_req <= 1'b0;
            err      <= 1'b1;
            state    <= IDLE;
          end
          if (wd_cnt != WD_MAX) wd_cnt <= wd_cnt + 1'b1;
`endif
        end

        DRAIN: begin
          if (out_ready) begin
            if (rd_ptr == LAST_IDX) begin
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              out_data  <= '0;
              state     <= IDLE;
            end else begin
              rd_ptr   <= rd_ptr + 1'b1;
              out_data <= res_buf[rd_nxt];
              out_last <= (rd_ptr == LAST_IDX - 1'b1);
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mm_iddmm_loader.sv
// Directed bench for mm_iddmm_loader at K=8, N=4 with a behavioural core model.
module tb_mm_iddmm_loader;

  localparam int K = 8;
  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [K-1:0] in_x = '0, in_y = '0, in_m = '0, in_m1 = '0;
  logic         wr_ena;
  logic [1:0]   wr_addr;
  logic [K-1:0] wr_x, wr_y, wr_m, wr_m1;
  logic         task_req;
  logic         task_end = 1'b0;
  logic         res_val = 1'b0;
  logic [K-1:0] res = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [K-1:0] out_data;
  logic         out_last;
  logic         busy;
  logic         err;

  int total = 0;
  int bad   = 0;

  logic [7:0] res_tbl [5] = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE};

  mm_iddmm_loader #(.K(K), .N(N), .TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_x(in_x), .in_y(in_y), .in_m(in_m), .in_m1(in_m1),
    .wr_ena(wr_ena), .wr_addr(wr_addr),
    .wr_x(wr_x), .wr_y(wr_y), .wr_m(wr_m), .wr_m1(wr_m1),
    .task_req(task_req), .task_end(task_end),
    .res_val(res_val), .res(res),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_last(out_last),
    .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_word(input logic [7:0] v);
    in_x  = v;
    in_y  = v ^ 8'hFF;
    in_m  = v + 8'h40;
    in_m1 = v + 8'h80;
  endtask

  // Loads base..base+3, checks each write pulse, and stops one cycle after the
  // last pulse with task_req expected high.
  task automatic load_words(input logic [7:0] base);
    logic [7:0] v;
    in_valid = 1'b1;
    set_word(base);
    tick;
    total++;
    if ({in_ready, busy, err} !== 3'b110) begin
      bad++;
      $display("FAIL load_entry ready/busy/err got=%b want=110", {in_ready, busy, err});
    end
    for (int i = 0; i < N; i++) begin
      tick;
      v = base + 8'(i);
      total++;
      if (wr_ena !== 1'b1 || wr_addr !== 2'(i) || wr_x !== v || wr_y !== (v ^ 8'hFF)
          || wr_m !== v + 8'h40 || wr_m1 !== v + 8'h80) begin
        bad++;
        $display("FAIL load_word%0d got ena=%b addr=%0d x=%h y=%h m=%h m1=%h want ena=1 addr=%0d x=%h",
                 i, wr_ena, wr_addr, wr_x, wr_y, wr_m, wr_m1, i, v);
      end
      if (i < N - 1) set_word(base + 8'(i + 1));
      else in_valid = 1'b0;
    end
    total++;
    if (in_ready !== 1'b0 || task_req !== 1'b0) begin
      bad++;
      $display("FAIL load_done ready=%b task_req=%b want 0 0", in_ready, task_req);
    end
    tick;
    total++;
    if (task_req !== 1'b1 || wr_ena !== 1'b0) begin
      bad++;
      $display("FAIL task_req_rise task_req=%b wr_ena=%b want 1 0", task_req, wr_ena);
    end
  endtask

  // Core model: nres result strobes then task_end; join_last overlaps the last strobe with task_end.
  task automatic core_respond(input int nres, input bit join_last);
    int plain;
    plain = join_last ? nres - 1 : nres;
    for (int i = 0; i < plain; i++) begin
      res_val = 1'b1;
      res     = res_tbl[i];
      tick;
    end
    res_val  = join_last;
    res      = join_last ? res_tbl[nres-1] : 8'h00;
    task_end = 1'b1;
    tick;
    res_val  = 1'b0;
    task_end = 1'b0;
    total++;
    if (task_req !== 1'b0) begin
      bad++;
      $display("FAIL task_req_drop got=%b want=0", task_req);
    end
  endtask

  // Drains with out_ready following ready_pat (bit 0 first), checking order, holds and out_last.
  task automatic drain_check(input logic [3:0] ready_pat, input logic exp_err);
    int         hs;
    bit         stalled;
    logic [7:0] pd;
    logic       pl;
    hs = 0;
    stalled = 1'b0;
    pd = '0;
    pl = 1'b0;
    for (int c = 0; c < 40 && hs < N; c++) begin
      total++;
      if (out_valid !== 1'b1) begin
        bad++;
        $display("FAIL drain_valid cycle%0d got=%b want=1", c, out_valid);
      end
      if (stalled) begin
        total++;
        if (out_data !== pd || out_last !== pl) begin
          bad++;
          $display("FAIL drain_hold got=%h/%b want=%h/%b", out_data, out_last, pd, pl);
        end
      end
      out_ready = ready_pat[c % 4];
      if (out_ready) begin
        total++;
        if (out_data !== res_tbl[hs] || out_last !== (hs == N - 1)) begin
          bad++;
          $display("FAIL drain_word%0d got=%h last=%b want=%h last=%b",
                   hs, out_data, out_last, res_tbl[hs], hs == N - 1);
        end
        hs++;
        stalled = 1'b0;
      end else begin
        stalled = 1'b1;
        pd = out_data;
        pl = out_last;
      end
      tick;
    end
    out_ready = 1'b0;
    total++;
    if (hs != N || out_valid !== 1'b0 || busy !== 1'b0 || err !== exp_err) begin
      bad++;
      $display("FAIL drain_end hs=%0d valid=%b busy=%b err=%b want hs=%0d 0 0 err=%b",
               hs, out_valid, busy, err, N, exp_err);
    end
  endtask

  task automatic test_reset;
    #12;
    total++;
    if ({in_ready, wr_ena, task_req, out_valid, out_last, busy, err} !== 7'b0) begin
      bad++;
      $display("FAIL reset_ctrl got=%b want=0000000",
               {in_ready, wr_ena, task_req, out_valid, out_last, busy, err});
    end
    total++;
    if (wr_addr !== '0 || wr_x !== '0 || wr_m1 !== '0 || out_data !== '0) begin
      bad++;
      $display("FAIL reset_data addr=%0d x=%h m1=%h out=%h want 0", wr_addr, wr_x, wr_m1, out_data);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick;
  endtask

  task automatic test_basic;
    load_words(8'h01);
    core_respond(4, 1'b0);
    drain_check(4'b1111, 1'b0);
  endtask

  task automatic test_stall;
    load_words(8'h11);
    core_respond(4, 1'b0);
    drain_check(4'b0101, 1'b0);
  endtask

  task automatic test_overflow;
    load_words(8'h21);
    core_respond(5, 1'b0);
    total++;
    if (err !== 1'b1 || out_valid !== 1'b1) begin
      bad++;
      $display("FAIL overflow_err err=%b valid=%b want 1 1", err, out_valid);
    end
    drain_check(4'b1111, 1'b1);
  endtask

  task automatic test_short;
    load_words(8'h31);
    core_respond(3, 1'b0);
    total++;
    if (err !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL short_end err=%b busy=%b valid=%b want 1 0 0", err, busy, out_valid);
    end
    for (int i = 0; i < 5; i++) begin
      tick;
      total++;
      if (out_valid !== 1'b0) begin
        bad++;
        $display("FAIL short_no_valid cycle%0d got=%b want=0", i, out_valid);
      end
    end
  endtask

  task automatic test_reset_midload;
    in_valid = 1'b1;
    set_word(8'h41);
    tick;
    tick;
    set_word(8'h42);
    tick;
    rst_n = 1'b0;
    #1;
    total++;
    if ({wr_ena, busy, in_ready, task_req, err} !== 5'b0) begin
      bad++;
      $display("FAIL midload_reset got=%b want=00000", {wr_ena, busy, in_ready, task_req, err});
    end
    in_valid = 1'b0;
    tick;
    rst_n = 1'b1;
    tick;
    load_words(8'h51);
    core_respond(4, 1'b1);
    drain_check(4'b1111, 1'b0);
  endtask

`ifdef IDDMM_LD_TIMEOUT_EN
  // RUN lasts TIMEOUT=16 cycles; task_req rose one cycle into RUN, so 15 more edges.
  task automatic test_timeout;
    int n;
    load_words(8'h61);
    n = 0;
    while (task_req === 1'b1 && n < 40) begin
      tick;
      n++;
    end
    total++;
    if (n != 15 || err !== 1'b1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL timeout cycles=%0d err=%b busy=%b want 15 1 0", n, err, busy);
    end
  endtask
`endif

  initial begin
    test_reset;
    test_basic;
    test_stall;
    test_overflow;
    test_short;
    test_reset_midload;
`ifdef IDDMM_LD_TIMEOUT_EN
    test_timeout;
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mm_iddmm_loader.md
Name: mm_iddmm_loader

Overview:
- Host-side initiator for mm_iddmm_sp: drives the operand write port (wr_ena/wr_addr/wr_x/wr_y/wr_m/wr_m1) and the task_req/task_end handshake, which FPGA-level tops currently tie off.
- Accepts N operand words from an upstream valid/ready stream, loads them into the core and starts a task.
- Captures the N result words the core emits on res_val into an internal buffer, then replays them on a downstream valid/ready stream.
- Sits between a host/DMA interface and mm_iddmm_sp.

Parameters:
- K, 128, word width in bits (matches the core's K)
- N, 32, words per operand (matches the core's N); power of two, N>=2
- TIMEOUT, 65536, watchdog limit in cycles; used only with the optional feature
- AW, $clog2(N), address width (localparam)

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operand word valid
- in_ready  out  1  operand word accepted
- in_x, in_y, in_m, in_m1  in  K each  operand word, least-significant word first
- wr_ena  out  1  core RAM write strobe
- wr_addr  out  AW  core RAM word address
- wr_x, wr_y, wr_m, wr_m1  out  K each  core write data
- task_req  out  1  task request to the core
- task_end  in  1  task complete from the core
- res_val  in  1  result word strobe from the core
- res  in  K  result word from the core
- out_valid  out  1  result word valid
- out_ready  in  1  downstream accept
- out_data  out  K  result word, least-significant word first
- out_last  out  1  high on word N-1
- busy  out  1  high in any state other than IDLE
- err  out  1  sticky error flag; cleared only on reset or on the next LOAD entry

Behaviour:
- Reset values: all outputs 0; state IDLE; all pointers 0; buffer contents don't-care.
- FSM states: IDLE, LOAD, RUN, DRAIN.
- IDLE -> LOAD when in_valid=1. in_ready=0 in IDLE, so that cycle does not transfer data. err clears on entry to LOAD.
- LOAD:
  - in_ready=1.
  - Each in_valid&in_ready handshake registers the data onto wr_* with wr_addr=ld_ptr and wr_ena=1 the next cycle (1-cycle latency); ld_ptr then increments.
  - wr_ena pulses exactly once per accepted word and is 0 otherwise.
  - After word N-1 is accepted: in_ready=0 the next cycle, move to RUN.
- RUN:
  - task_req is asserted 1 cycle after the last wr_ena pulse and held until task_end is sampled high.
  - Each res_val=1 cycle writes res into buf[cap_ptr]; cap_ptr increments.
  - After N captures, further res_val strobes are ignored and err is set.
  - task_end high: task_req drops the next cycle. A res_val in the same cycle as task_end is captured.
  - Then -> DRAIN if cap_ptr==N; otherwise set err and -> IDLE.
- DRAIN:
  - out_valid=1; out_data=buf[rd_ptr]; out_last=(rd_ptr==N-1).
  - rd_ptr advances on out_valid&out_ready.
  - out_data and out_last remain stable while out_ready=0.
  - After the last handshake: out_valid=0 the next cycle, -> IDLE.
- Pointers are AW+1 bits so a value of N is representable; no wrap occurs within a task.
- The core is never backpressured: res_val is never dropped while fewer than N words are captured.
- Asserting rst_n low mid-operation:
  - Immediately clears task_req, wr_ena, out_valid and the FSM.
  - A partially loaded operand is abandoned.
  - The core must be reset together with this block.

Optional Feature:
- Macro IDDMM_LD_TIMEOUT_EN.
- Defined: a watchdog counts cycles in RUN. When it reaches TIMEOUT-1 without task_end: task_req drops the next cycle, err=1, FSM -> IDLE, and captured data is discarded.
- Not defined: RUN waits indefinitely for task_end; no counter logic is synthesised.

Test Plan (K=8, N=4):
- Load x=01,02,03,04, no stall -> wr_ena pulses at wr_addr 0..3 with wr_x 01..04 on 4 consecutive cycles; task_req rises 1 cycle after the last pulse.
- Core model returns res AA,BB,CC,DD then task_end, out_ready=1 -> out_data AA,BB,CC,DD; out_last only on DD; busy=0 afterwards.
- out_ready toggled 1010 during DRAIN -> out_data held on stall cycles; exactly 4 handshakes; no word dropped or duplicated.
- Core emits 5 res_val before task_end -> first 4 words stream out, 5th ignored, err=1.
- Core emits 3 res_val then task_end -> err=1, FSM returns to IDLE, out_valid never asserts.
- rst_n pulsed low after 2 loaded words; then a full reload of 4 words -> wr_addr restarts at 0 and the task completes normally. With IDDMM_LD_TIMEOUT_EN and TIMEOUT=16, withholding task_end -> task_req drops after 16 cycles and err=1.
